key_debouncer: RTL and testbench

- Conditions raw push-button inputs before they reach the edge/one-shot pulse stage of the memory-control front panel.
- Per key:
  - synchronises the asynchronous pad signal into clk;
  - normalises polarity so that 1 means pressed;
  - filters contact bounce with a per-key stability counter.
- The output key_clean is a glitch-free level that drives the pulse stage's key input directly.

---
 rtl/key_debouncer_if.sv | 11 +
 rtl/key_debouncer.sv | 86 ++++++++
 tb/tb_key_debouncer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/key_debouncer_if.sv
// Key pad bundle: raw pad levels in, debounced levels and qualification flags out.
interface key_debouncer_if #(
    parameter int NUM_KEYS = 1
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_clean;
    logic [NUM_KEYS-1:0] key_bouncing;

    modport master (output key_raw, input key_clean, input key_bouncing);
    modport slave  (input key_raw, output key_clean, output key_bouncing);
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchroniser, polarity normalisation and stability-counter debounce.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges from the first sample; no backpressure, pure level output.
module key_debouncer #(
    parameter int NUM_KEYS        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    key_debouncer_if.slave  key_if
);

    localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RELEASED_LVL = ACTIVE_LOW;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("key_debouncer: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $error("key_debouncer: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } key_state_t;

    logic [NUM_KEYS-1:0] clean_vec;
    logic [NUM_KEYS-1:0] bouncing_vec;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_pressed;
        logic [CW-1:0]          cnt_q;
        logic [CW-1:0]          cnt_d;
        key_state_t             state_q;
        key_state_t             state_d;

        // Reset to the released pad level so no phantom press is seen after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{RELEASED_LVL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], key_if.key_raw[k]};
            end
        end

        assign s_pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Any reversion to the accepted level wipes the count: no partial credit.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (s_pressed == (state_q == ST_PRESSED)) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = s_pressed ? ST_PRESSED : ST_RELEASED;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        assign clean_vec[k]    = (state_q == ST_PRESSED);
        assign bouncing_vec[k] = (cnt_q != '0);
    end

    assign key_if.key_clean    = clean_vec;
    assign key_if.key_bouncing = bouncing_vec;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: active-low and active-high instances driven with complementary pads.
module tb_key_debouncer;

    localparam int NK   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk;
    logic rst_n;

    key_debouncer_if #(.NUM_KEYS(NK)) if_lo ();
    key_debouncer_if #(.NUM_KEYS(NK)) if_hi ();

    key_debouncer #(
        .NUM_KEYS(NK), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .key_if(if_lo)
    );

    key_debouncer #(
        .NUM_KEYS(NK), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .key_if(if_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a key's accepted level flips once DEB consecutive delayed samples
    // disagree with it; any agreeing sample forgets the streak.
    logic [NK-1:0] m_clean;
    logic [NK-1:0] m_bnc;
    int            m_run [NK];
    logic [NK-1:0] m_dly [$];

    task automatic model_reset();
        m_clean = '0;
        m_bnc   = '0;
        m_dly   = {};
        for (int i = 0; i < SYNC; i++) m_dly.push_back('0);
        for (int k = 0; k < NK; k++) m_run[k] = 0;
    endtask

    task automatic model_step(input logic [NK-1:0] raw);
        logic [NK-1:0] s;
        m_dly.push_back(~raw);
        s = m_dly.pop_front();
        for (int k = 0; k < NK; k++) begin
            if (s[k] == m_clean[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == DEB) begin
                    m_clean[k] = s[k];
                    m_run[k]   = 0;
                end
            end
            m_bnc[k] = (m_run[k] != 0);
        end
    endtask

    // raw is the active-low pad view; the active-high DUT gets its complement.
    task automatic step(input logic [NK-1:0] raw);
        if_lo.key_raw = raw;
        if_hi.key_raw = ~raw;
        @(posedge clk);
        model_step(raw);
        @(negedge clk);
        check_eq("lo_clean", int'(if_lo.key_clean),    int'(m_clean));
        check_eq("lo_bnc",   int'(if_lo.key_bouncing), int'(m_bnc));
        check_eq("hi_clean", int'(if_hi.key_clean),    int'(m_clean));
        check_eq("hi_bnc",   int'(if_hi.key_bouncing), int'(m_bnc));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_lo_clean"}, int'(if_lo.key_clean),    0);
        check_eq({tag, "_lo_bnc"},   int'(if_lo.key_bouncing), 0);
        check_eq({tag, "_hi_clean"}, int'(if_hi.key_clean),    0);
        check_eq({tag, "_hi_bnc"},   int'(if_hi.key_bouncing), 0);
    endtask

    logic [NK-1:0] rnd_raw;

    initial begin
        rst_n         = 1'b0;
        if_lo.key_raw = 2'b11;
        if_hi.key_raw = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Idle after reset with keys released.
        for (int e = 1; e <= 20; e++) begin
            step(2'b11);
            check_eq("idle_clean", int'(if_lo.key_clean), 0);
            check_eq("idle_bnc",   int'(if_lo.key_bouncing), 0);
        end

        // Single press: bouncing after edges 3..5, accepted on edge 6; both polarities.
        for (int e = 1; e <= 8; e++) begin
            step(2'b10);
            check_eq("press_bnc_lo",   int'(if_lo.key_bouncing[0]), int'(e >= 3 && e <= 5));
            check_eq("press_clean_lo", int'(if_lo.key_clean[0]),    int'(e >= 6));
            check_eq("press_bnc_hi",   int'(if_hi.key_bouncing[0]), int'(e >= 3 && e <= 5));
            check_eq("press_clean_hi", int'(if_hi.key_clean[0]),    int'(e >= 6));
        end
        repeat (10) step(2'b11);
        check_eq("released", int'(if_lo.key_clean), 0);

        // Glitch of DEB-1 sampling edges is rejected.
        for (int e = 1; e <= 10; e++) begin
            step((e <= 3) ? 2'b10 : 2'b11);
            check_eq("glitch3_clean", int'(if_lo.key_clean[0]), 0);
            if (e >= 6) check_eq("glitch3_bnc", int'(if_lo.key_bouncing[0]), 0);
        end

        // Pulse of DEB sampling edges is accepted on edge 6, then released on edge 10.
        for (int e = 1; e <= 12; e++) begin
            step((e <= 4) ? 2'b10 : 2'b11);
            check_eq("pulse4_clean", int'(if_lo.key_clean[0]), int'(e >= 6 && e <= 9));
        end
        repeat (5) step(2'b11);

        // Bounce burst on press, final low level first sampled at t=10.
        for (int t = 0; t <= 20; t++) begin
            step((t < 10 && t % 2 == 1) ? 2'b11 : 2'b10);
            check_eq("burst_press", int'(if_lo.key_clean[0]), int'(t >= 15));
        end
        // Bounce burst on release.
        for (int t = 0; t <= 20; t++) begin
            step((t < 10 && t % 2 == 1) ? 2'b10 : 2'b11);
            check_eq("burst_release", int'(if_lo.key_clean[0]), int'(t < 15));
        end

        // Key1 pressed on the same edge key0 is released.
        repeat (10) step(2'b10);
        check_eq("k0_held", int'(if_lo.key_clean), 1);
        for (int e = 1; e <= 8; e++) begin
            step(2'b01);
            check_eq("indep_k0", int'(if_lo.key_clean[0]), int'(e < 6));
            check_eq("indep_k1", int'(if_lo.key_clean[1]), int'(e >= 6));
            check_eq("indep_k1_hi", int'(if_hi.key_clean[1]), int'(e >= 6));
        end
        repeat (10) step(2'b11);

        // Reset while key0 is mid-qualification (count 2 after edge 4).
        for (int e = 1; e <= 4; e++) step(2'b10);
        check_eq("pre_rst_bnc", int'(if_lo.key_bouncing[0]), 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        check_zero("midrst_hold");
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(2'b10);
            check_eq("post_rst_lo", int'(if_lo.key_clean[0]), int'(e >= 6));
            check_eq("post_rst_hi", int'(if_hi.key_clean[0]), int'(e >= 6));
        end

        // Random pads with long holds mixed in; the model checks every cycle.
        rnd_raw = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 5) == 0) rnd_raw[k] = ~rnd_raw[k];
            end
            step(rnd_raw);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
